// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_pkg
// Brief    : Shared widths and the ROB entry record for the reorder buffer.
// Revision : 1.0
// ============================================================================
package reorder_buffer_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int TAG_W     = 4;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic                 busy;
    logic                 ready;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      value;
    logic                 is_branch;
    logic                 pred_taken;
    logic                 taken;
    logic [XLEN-1:0]      alt_pc;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : 16-entry in-order retirement buffer with mispredict flush.
// Revision : 1.0
// ============================================================================
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4,
  parameter int XLEN     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_is_branch,
  input  logic             alloc_pred_taken,
  input  logic [XLEN-1:0]  alloc_alt_pc,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             simple_ins_commit,
  input  logic [TAG_W-1:0] simple_ins_rename,
  input  logic [XLEN-1:0]  simple_ins_value,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             cdb_taken,
  output logic             register_update_flag,
  output logic [4:0]       register_commit_dest,
  output logic [XLEN-1:0]  register_commit_value,
  output logic [TAG_W-1:0] rename_of_commit_ins,
  output logic             rob_flush,
  output logic [XLEN-1:0]  flush_pc,
  output logic             rob_empty
);

  localparam logic [TAG_W:0] FULL_COUNT = ROB_SIZE[TAG_W:0];

  rob_entry_t       r_entries [ROB_SIZE];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  rob_entry_t w_head_entry;
  logic       w_commit;
  logic       w_mispredict;
  logic       w_alloc;

  assign w_head_entry = r_entries[r_head];
  assign w_commit     = rdy && w_head_entry.busy && w_head_entry.ready;
  assign w_mispredict = w_commit && w_head_entry.is_branch &&
                        (w_head_entry.taken != w_head_entry.pred_taken);
  assign w_alloc      = rdy && alloc_valid && alloc_ready && !w_mispredict;

  assign alloc_ready = (r_count != FULL_COUNT);
  assign alloc_tag   = r_tail;
  assign rob_empty   = (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head                <= '0;
      r_tail                <= '0;
      r_count               <= '0;
      register_update_flag  <= 1'b0;
      register_commit_dest  <= '0;
      register_commit_value <= '0;
      rename_of_commit_ins  <= '0;
      rob_flush             <= 1'b0;
      flush_pc              <= '0;
      for (int i = 0; i < ROB_SIZE; i++) r_entries[i] <= '0;
    end else if (!rdy) begin
      // Pulses drop while frozen so a stalled commit is not seen twice.
      register_update_flag <= 1'b0;
      rob_flush            <= 1'b0;
    end else begin
      register_update_flag <= 1'b0;
      rob_flush            <= 1'b0;

      if (w_commit) begin
        register_update_flag  <= (w_head_entry.rd != '0);
        register_commit_dest  <= w_head_entry.rd;
        register_commit_value <= w_head_entry.value;
        rename_of_commit_ins  <= r_head;
      end

      if (w_mispredict) begin
        // Retiring mispredict squashes every younger entry and this cycle's traffic.
        rob_flush <= 1'b1;
        flush_pc  <= w_head_entry.alt_pc;
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          r_entries[i].busy  <= 1'b0;
          r_entries[i].ready <= 1'b0;
        end
      end else begin
        if (simple_ins_commit && r_entries[simple_ins_rename].busy) begin
          r_entries[simple_ins_rename].ready <= 1'b1;
          r_entries[simple_ins_rename].value <= simple_ins_value;
        end
        if (cdb_valid && r_entries[cdb_tag].busy) begin
          r_entries[cdb_tag].ready <= 1'b1;
          r_entries[cdb_tag].value <= cdb_value;
          r_entries[cdb_tag].taken <= cdb_taken;
        end
        // taken starts at the prediction so non-CDB completions never flush.
        if (w_alloc) begin
          r_entries[r_tail] <= '{busy:       1'b1,
                                 ready:      1'b0,
                                 rd:         alloc_rd,
                                 value:      '0,
                                 is_branch:  alloc_is_branch,
                                 pred_taken: alloc_pred_taken,
                                 taken:      alloc_pred_taken,
                                 alt_pc:     alloc_alt_pc};
          r_tail <= r_tail + 1'b1;
        end
        if (w_commit) begin
          r_entries[r_head].busy <= 1'b0;
          r_head                 <= r_head + 1'b1;
        end
        case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Directed and random stimulus against a queue-based ROB model.
// Revision : 1.0
// ============================================================================
module tb_reorder_buffer;

  localparam int NENT = 16;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_valid, alloc_is_branch, alloc_pred_taken;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_alt_pc;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        simple_ins_commit;
  logic [3:0]  simple_ins_rename;
  logic [31:0] simple_ins_value;
  logic        cdb_valid, cdb_taken;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        register_update_flag, rob_flush, rob_empty;
  logic [4:0]  register_commit_dest;
  logic [31:0] register_commit_value, flush_pc;
  logic [3:0]  rename_of_commit_ins;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_is_branch(alloc_is_branch), .alloc_pred_taken(alloc_pred_taken),
    .alloc_alt_pc(alloc_alt_pc), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .simple_ins_commit(simple_ins_commit), .simple_ins_rename(simple_ins_rename),
    .simple_ins_value(simple_ins_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .register_update_flag(register_update_flag), .register_commit_dest(register_commit_dest),
    .register_commit_value(register_commit_value), .rename_of_commit_ins(rename_of_commit_ins),
    .rob_flush(rob_flush), .flush_pc(flush_pc), .rob_empty(rob_empty)
  );

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [31:0] value;
    bit          ready;
    bit          is_br;
    bit          pred;
    bit          taken;
    logic [31:0] alt_pc;
  } m_ent_t;

  typedef struct {
    logic        flag;
    logic        flush;
    logic [4:0]  dest;
    logic [31:0] value;
    logic [3:0]  tag;
    logic [31:0] fpc;
    logic        empty;
    logic        aready;
    logic [3:0]  atag;
  } exp_t;

  m_ent_t rob[$];
  int     next_tag = 0;
  exp_t   cur;
  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model: program-order queue of in-flight instructions.
  always @(posedge clk) begin : model
    bit can_alloc;
    bit mis;
    m_ent_t e;
    if (rst) begin
      rob.delete();
      next_tag = 0;
      cur = '{default: '0};
    end else if (!rdy) begin
      cur.flag  = 1'b0;
      cur.flush = 1'b0;
    end else begin
      can_alloc = rob.size() < NENT;
      mis       = 1'b0;
      cur.flag  = 1'b0;
      cur.flush = 1'b0;
      if (rob.size() > 0 && rob[0].ready) begin
        e         = rob.pop_front();
        mis       = e.is_br && (e.taken != e.pred);
        cur.dest  = e.rd;
        cur.value = e.value;
        cur.tag   = 4'(e.tag);
        cur.flag  = (e.rd != 5'd0);
        if (mis) begin
          cur.flush = 1'b1;
          cur.fpc   = e.alt_pc;
        end
      end
      if (mis) begin
        rob.delete();
        next_tag = 0;
      end else begin
        foreach (rob[i]) begin
          if (simple_ins_commit && rob[i].tag == int'(simple_ins_rename)) begin
            rob[i].ready = 1'b1;
            rob[i].value = simple_ins_value;
          end
          if (cdb_valid && rob[i].tag == int'(cdb_tag)) begin
            rob[i].ready = 1'b1;
            rob[i].value = cdb_value;
            rob[i].taken = cdb_taken;
          end
        end
        if (alloc_valid && can_alloc) begin
          e = '{tag: next_tag, rd: alloc_rd, value: 32'd0, ready: 1'b0,
                is_br: alloc_is_branch, pred: alloc_pred_taken,
                taken: alloc_pred_taken, alt_pc: alloc_alt_pc};
          rob.push_back(e);
          next_tag = (next_tag + 1) % NENT;
        end
      end
    end
    cur.empty  = (rob.size() == 0);
    cur.aready = (rob.size() < NENT);
    cur.atag   = 4'(next_tag);
    exp_q.push_back(cur);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("register_update_flag",  32'(register_update_flag),  32'(x.flag));
      chk("rob_flush",             32'(rob_flush),             32'(x.flush));
      chk("register_commit_dest",  32'(register_commit_dest),  32'(x.dest));
      chk("register_commit_value", register_commit_value,      x.value);
      chk("rename_of_commit_ins",  32'(rename_of_commit_ins),  32'(x.tag));
      chk("flush_pc",              flush_pc,                   x.fpc);
      chk("rob_empty",             32'(rob_empty),             32'(x.empty));
      chk("alloc_ready",           32'(alloc_ready),           32'(x.aready));
      chk("alloc_tag",             32'(alloc_tag),             32'(x.atag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rst               = 1'b0;
    rdy               = 1'b1;
    alloc_valid       = 1'b0;
    cdb_valid         = 1'b0;
    simple_ins_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
  endtask

  task automatic alloc(input logic [4:0] rd, input bit br, input bit pred, input logic [31:0] alt);
    alloc_valid      = 1'b1;
    alloc_rd         = rd;
    alloc_is_branch  = br;
    alloc_pred_taken = pred;
    alloc_alt_pc     = alt;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input bit tk);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
    cdb_taken = tk;
  endtask

  task automatic simple(input logic [3:0] tag, input logic [31:0] val);
    simple_ins_commit = 1'b1;
    simple_ins_rename = tag;
    simple_ins_value  = val;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int pend[$];
    int ct;
    rst = 1'b1; rdy = 1'b1;
    alloc_valid = 1'b0; alloc_rd = '0; alloc_is_branch = 1'b0; alloc_pred_taken = 1'b0;
    alloc_alt_pc = '0;
    simple_ins_commit = 1'b0; simple_ins_rename = '0; simple_ins_value = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_taken = 1'b0;
    do_reset(); do_reset();

    // Out-of-order completion, in-order commit
    alloc(5'd5, 0, 0, 0); step();
    alloc(5'd6, 0, 0, 0); step();
    alloc(5'd7, 0, 0, 0); step();
    cdb(4'd2, 32'h2222, 0); step();
    cdb(4'd0, 32'h0000_0a0a, 0); step();
    cdb(4'd1, 32'h1111, 0); step();
    idle(4);

    // Fill to capacity, overflow request, then wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      alloc(5'(i + 1), 0, 0, 32'(i)); step();
    end
    cdb(4'd0, 32'hbeef, 0); step();
    alloc(5'd20, 0, 0, 0); step();
    step();
    alloc(5'd21, 0, 0, 0); step();
    idle(2);

    // rd = 0 retires without a register update
    do_reset();
    alloc(5'd0, 0, 0, 0); step();
    cdb(4'd0, 32'h1234, 0); step();
    idle(3);

    // Mispredicted branch at tag 3 with younger entries behind it
    do_reset();
    alloc(5'd1, 0, 0, 0); step();
    alloc(5'd2, 0, 0, 0); step();
    alloc(5'd3, 0, 0, 0); step();
    cdb(4'd0, 32'h10, 0); step();
    cdb(4'd1, 32'h11, 0); step();
    cdb(4'd2, 32'h12, 0); step();
    alloc(5'd0, 1, 0, 32'h100); step();
    alloc(5'd4, 0, 0, 0); step();
    alloc(5'd5, 0, 0, 0); step();
    alloc(5'd6, 0, 0, 0); step();
    cdb(4'd3, 32'h0, 1); cdb_valid = 1'b1; step();
    idle(2);
    alloc(5'd9, 0, 0, 0); step();
    idle(2);

    // Simple-path and CDB completions in the same cycle
    do_reset();
    alloc(5'd8, 0, 0, 0); step();
    alloc(5'd9, 0, 0, 0); step();
    simple(4'd0, 32'hABCD); cdb(4'd1, 32'h5555, 0); step();
    idle(3);

    // rdy held low while head is ready
    do_reset();
    alloc(5'd10, 0, 0, 0); step();
    cdb(4'd0, 32'h77, 0); step();
    for (int i = 0; i < 3; i++) begin
      rdy = 1'b0; step();
    end
    idle(3);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(199) == 0) rst = 1'b1;
      rdy = ($urandom_range(9) != 0);
      if ($urandom_range(9) < 6)
        alloc(5'($urandom_range(31)), ($urandom_range(4) == 0), 1'($urandom_range(1)), $urandom);
      pend.delete();
      foreach (rob[i]) if (!rob[i].ready) pend.push_back(rob[i].tag);
      ct = -1;
      if (pend.size() > 0 && $urandom_range(1) == 1) begin
        ct = pend[$urandom_range(pend.size() - 1)];
        cdb(4'(ct), $urandom, 1'($urandom_range(1)));
      end else if ($urandom_range(9) == 0) begin
        cdb(4'($urandom_range(15)), $urandom, 1'($urandom_range(1)));
        ct = int'(cdb_tag);
      end
      if (pend.size() > 0 && $urandom_range(2) == 0) begin
        int st;
        st = pend[$urandom_range(pend.size() - 1)];
        if (st != ct) simple(4'(st), $urandom);
      end
      step();
    end

    // Drain: complete everything still pending
    for (int n = 0; n < 40; n++) begin
      pend.delete();
      foreach (rob[i]) if (!rob[i].ready) pend.push_back(rob[i].tag);
      if (pend.size() > 0) cdb(4'(pend[0]), $urandom, 1'($urandom_range(1)));
      step();
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
